// File: rtl/mu0_control.sv
// MU0 multi-cycle control unit: fetch/execute sequencing with a bounded Mem_Ready wait.
// Optional MU0_INSTR_COUNT_EN adds a retired-instruction counter output.
`timescale 1ns/1ps
module mu0_control #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  F,
  input  logic        N,
  input  logic        Z,
  input  logic        Mem_Ready,
  output logic        X_sel,
  output logic        Y_sel,
  output logic        Addr_sel,
  output logic [1:0]  ALU_fs,
  output logic        PC_En,
  output logic        IR_En,
  output logic        Acc_En,
  output logic        MEM_rd,
  output logic        MEM_wr,
  output logic        Halted,
  output logic        Bus_Err,
`ifdef MU0_INSTR_COUNT_EN
  output logic [15:0] Instr_Count,
`endif
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXECUTE = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic          mem_state;
  logic          timeout;
  logic          done;

  assign state_dbg = state;

  // FETCH always touches memory; in EXECUTE only LDA/STA/ADD/SUB (0-3) do.
  assign mem_state = (state == S_FETCH) ||
                     ((state == S_EXECUTE) && (F[3:2] == 2'b00));
  assign timeout   = (WAIT_LIMIT != 0) && mem_state && !Mem_Ready &&
                     (wait_cnt == CW'(WAIT_LIMIT));
  assign done      = mem_state ? Mem_Ready : 1'b1;

  always_comb begin
    next_state = state;
    if (timeout) begin
      next_state = S_HALT;
    end else begin
      case (state)
        S_FETCH:   if (Mem_Ready) next_state = S_EXECUTE;
        S_EXECUTE: if (done) next_state = (F == 4'd7) ? S_HALT : S_FETCH;
        default:   next_state = S_HALT;
      endcase
    end
  end

  always_comb begin
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    ALU_fs   = 2'b00;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    MEM_rd   = 1'b0;
    MEM_wr   = 1'b0;
    Halted   = 1'b0;
    // Reset gates everything so no register write can slip through mid-instruction.
    if (!Reset) begin
      case (state)
        S_FETCH: begin
          MEM_rd = 1'b1;
          X_sel  = 1'b1;
          ALU_fs = 2'b10;
          IR_En  = Mem_Ready;
          PC_En  = Mem_Ready;
        end
        S_EXECUTE: begin
          case (F)
            4'd0: begin
              Addr_sel = 1'b1;
              MEM_rd   = 1'b1;
              Acc_En   = Mem_Ready;
            end
            4'd1: begin
              Addr_sel = 1'b1;
              MEM_wr   = 1'b1;
            end
            4'd2, 4'd3: begin
              Addr_sel = 1'b1;
              MEM_rd   = 1'b1;
              ALU_fs   = F[0] ? 2'b11 : 2'b01;
              Acc_En   = Mem_Ready;
            end
            4'd4: begin
              Y_sel = 1'b1;
              PC_En = 1'b1;
            end
            4'd5: begin
              Y_sel = 1'b1;
              PC_En = ~N;
            end
            4'd6: begin
              Y_sel = 1'b1;
              PC_En = ~Z;
            end
            default: ;
          endcase
        end
        S_HALT:  Halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      Bus_Err  <= 1'b0;
    end else begin
      state   <= next_state;
      Bus_Err <= Bus_Err | timeout;
      if ((WAIT_LIMIT != 0) && mem_state && !Mem_Ready && (next_state == state))
        wait_cnt <= wait_cnt + CW'(1);
      else
        wait_cnt <= '0;
    end
  end

`ifdef MU0_INSTR_COUNT_EN
  // Counts every instruction retiring from EXECUTE; a timeout is not a retirement.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      Instr_Count <= 16'd0;
    else if ((state == S_EXECUTE) && done && !timeout)
      Instr_Count <= Instr_Count + 16'd1;
  end
`endif

endmodule

// File: doc/mu0_control.md
Name: mu0_control

Overview:
- Multi-cycle control unit for the MU0 16-bit datapath: program counter (PC), instruction register (IR), accumulator (Acc), ALU and the 16-bit 2:1 operand/address muxes.
- Sequences fetch/execute, drives the mux selects, register enables, ALU function and memory strobes.
- Supports a Mem_Ready wait-state handshake with a bounded-wait timeout.
- Sits beside the datapath in the MU0 top level; its only datapath inputs are opcode and flags.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive Mem_Ready-low cycles tolerated in one memory state before bus error. 0 disables the timeout.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- F  input  4  opcode, IR[15:12].
- N  input  1  Acc negative flag (Acc[15]).
- Z  input  1  Acc zero flag.
- Mem_Ready  input  1  memory completes the current access this cycle.
- X_sel  output  1  ALU X operand mux: 0=Acc, 1=PC.
- Y_sel  output  1  ALU Y operand mux: 0=memory data, 1=IR[11:0] zero-extended.
- Addr_sel  output  1  address mux: 0=PC, 1=IR[11:0].
- ALU_fs  output  2  00=Y, 01=X+Y, 10=X+1, 11=X-Y.
- PC_En  output  1  PC load enable.
- IR_En  output  1  IR load enable.
- Acc_En  output  1  Acc load enable.
- MEM_rd  output  1  memory read strobe.
- MEM_wr  output  1  memory write strobe.
- Halted  output  1  high in HALT.
- Bus_Err  output  1  sticky; set on wait timeout.

Behaviour:
- States: FETCH, EXECUTE, HALT. State register resets asynchronously to FETCH. Wait counter resets to 0. Bus_Err resets to 0.
- Outputs are combinational from state, F, N, Z and Mem_Ready. While Reset is high, all enables and strobes are 0 and Halted is 0.
- Default for every output not listed for a state/opcode: 0.
- FETCH: Addr_sel=0, MEM_rd=1, X_sel=1, ALU_fs=10.
  - IR_En and PC_En equal Mem_Ready.
  - Mem_Ready=1 -> EXECUTE; otherwise stay in FETCH.
- EXECUTE, by F:
  - 0 LDA: Addr_sel=1, MEM_rd=1, Y_sel=0, ALU_fs=00, Acc_En=Mem_Ready.
  - 1 STA: Addr_sel=1, MEM_wr=1, held until Mem_Ready.
  - 2 ADD: Addr_sel=1, MEM_rd=1, X_sel=0, Y_sel=0, ALU_fs=01, Acc_En=Mem_Ready.
  - 3 SUB: as ADD with ALU_fs=11.
  - 4 JMP: Y_sel=1, ALU_fs=00, PC_En=1. No memory access; completes in one cycle.
  - 5 JGE: as JMP with PC_En=~N.
  - 6 JNE: as JMP with PC_En=~Z.
  - 7 STP: no enables; next state HALT.
  - 8-F: NOP, one cycle, no enables.
- Memory opcodes (0-3) leave EXECUTE for FETCH only when Mem_Ready=1. Opcodes 4-6 and 8-F return to FETCH after one cycle.
- N and Z are sampled in the same cycle as PC_En; Acc does not change in EXECUTE of a jump.
- Nominal latency with Mem_Ready tied high: 2 cycles per instruction.
- Wait timeout:
  - Counter increments each cycle in a memory state with Mem_Ready=0; clears on Mem_Ready=1 or state change.
  - When the counter reaches WAIT_LIMIT with Mem_Ready still 0: Bus_Err<=1, next state HALT, no enable asserted that cycle.
  - Mem_Ready rising exactly on the limit cycle completes normally (no error).
- HALT: all enables and strobes 0, Halted=1. Exited only by Reset, which also clears Bus_Err.
- Reset mid-instruction: outputs drop to 0 immediately; no partial register write completes after Reset asserts.

Optional Feature:
- Macro MU0_INSTR_COUNT_EN.
- Defined: adds output Instr_Count [15:0].
  - Resets to 0; increments by 1 on the cycle each instruction leaves EXECUTE (including STP and NOP).
  - Wraps FFFF->0000; frozen in HALT and while waiting.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then release with Mem_Ready=1 and F=0 (LDA) -> cycle 1 FETCH: MEM_rd=1, IR_En=1, PC_En=1, ALU_fs=10. Cycle 2: Addr_sel=1, Acc_En=1, ALU_fs=00.
- F=2 (ADD), then F=3 (SUB), Mem_Ready=1 -> ALU_fs 01 then 11, X_sel=0, Y_sel=0, Acc_En=1. Each instruction takes 2 cycles.
- F=5 (JGE) with N=1 -> PC_En=0. Repeat with N=0 -> PC_En=1, Y_sel=1. F=6 (JNE) with Z=1 -> PC_En=0.
- F=1 (STA) with Mem_Ready low for 3 cycles -> MEM_wr=1 and Addr_sel=1 held 4 cycles. No enables assert. FETCH follows.
- WAIT_LIMIT=4, Mem_Ready held 0 in FETCH -> Bus_Err=1 and Halted=1 after 4 wait cycles. Reset pulse -> both clear and FETCH resumes.
- F=7 (STP) -> Halted=1 next cycle, outputs stay 0 for 20 cycles. With MU0_INSTR_COUNT_EN, after 5 instructions plus STP, Instr_Count=6.
